// File: rtl/axi_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_master
// Purpose  : AXI4-Lite initiator. Converts single-beat commands taken on a
//            valid/ready command port into AXI4-Lite write or read
//            transactions. Returns exactly one response per command on a
//            valid/ready response port. Only one transaction is outstanding
//            at a time. A per-transaction watchdog can abort a stalled
//            transaction and report SLVERR with a timeout flag.
// Ports    : clk, rst (async, active-low)
//            cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata/cmd_wstrb
//            rsp_valid/rsp_ready/rsp_rdata/rsp_resp/rsp_timeout
//            m00_axi_aw*, m00_axi_w*, m00_axi_b*, m00_axi_ar*, m00_axi_r*
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_master #(
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int C_M00_AXI_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES       = 255
) (
    input  logic                                clk,
    input  logic                                rst,
    // command port
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic                                cmd_write,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M00_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    // response port
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                          rsp_resp,
    output logic                                rsp_timeout,
    // AXI4-Lite master
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
    output logic [2:0]                          m00_axi_awprot,
    output logic                                m00_axi_awvalid,
    input  logic                                m00_axi_awready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
    output logic [C_M00_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
    output logic                                m00_axi_wvalid,
    input  logic                                m00_axi_wready,
    input  logic [1:0]                          m00_axi_bresp,
    input  logic                                m00_axi_bvalid,
    output logic                                m00_axi_bready,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
    output logic [2:0]                          m00_axi_arprot,
    output logic                                m00_axi_arvalid,
    input  logic                                m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
    input  logic [1:0]                          m00_axi_rresp,
    input  logic                                m00_axi_rvalid,
    output logic                                m00_axi_rready
);

    localparam int STRB_W = C_M00_AXI_DATA_WIDTH / 8;
    // Counter must hold TIMEOUT_CYCLES itself: a handshake landing on the
    // limit cycle in WR lets the count run one past the last value.
    localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic TO_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4,
        S_RSP     = 3'd5
    } state_t;

    state_t                             state, state_nx;
    logic [C_M00_AXI_ADDR_WIDTH-1:0]    addr_q, addr_nx;
    logic [C_M00_AXI_DATA_WIDTH-1:0]    wdata_q, wdata_nx;
    logic [STRB_W-1:0]                  wstrb_q, wstrb_nx;
    logic                               awvalid_q, awvalid_nx;
    logic                               wvalid_q, wvalid_nx;
    logic                               arvalid_q, arvalid_nx;
    logic                               cmd_ready_q, cmd_ready_nx;
    logic                               rsp_valid_q, rsp_valid_nx;
    logic [C_M00_AXI_DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_nx;
    logic [1:0]                         rsp_resp_q, rsp_resp_nx;
    logic                               rsp_timeout_q, rsp_timeout_nx;
    logic [TO_W-1:0]                    tcount_q, tcount_nx;

    logic busy;
    logic to_hit;
    logic abort;
    logic aw_left;
    logic w_left;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
            tcount_q      <= '0;
        end else begin
            state         <= state_nx;
            addr_q        <= addr_nx;
            wdata_q       <= wdata_nx;
            wstrb_q       <= wstrb_nx;
            awvalid_q     <= awvalid_nx;
            wvalid_q      <= wvalid_nx;
            arvalid_q     <= arvalid_nx;
            cmd_ready_q   <= cmd_ready_nx;
            rsp_valid_q   <= rsp_valid_nx;
            rsp_rdata_q   <= rsp_rdata_nx;
            rsp_resp_q    <= rsp_resp_nx;
            rsp_timeout_q <= rsp_timeout_nx;
            tcount_q      <= tcount_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        addr_nx        = addr_q;
        wdata_nx       = wdata_q;
        wstrb_nx       = wstrb_q;
        awvalid_nx     = awvalid_q;
        wvalid_nx      = wvalid_q;
        arvalid_nx     = arvalid_q;
        cmd_ready_nx   = cmd_ready_q;
        rsp_valid_nx   = rsp_valid_q;
        rsp_rdata_nx   = rsp_rdata_q;
        rsp_resp_nx    = rsp_resp_q;
        rsp_timeout_nx = rsp_timeout_q;
        abort          = 1'b0;
        aw_left        = awvalid_q & ~m00_axi_awready;
        w_left         = wvalid_q & ~m00_axi_wready;

        busy      = (state == S_WR) || (state == S_WR_RESP) ||
                    (state == S_RD_ADDR) || (state == S_RD_DATA);
        // >= rather than == so a transaction that slipped past the limit via
        // a same-cycle AW/W handshake still times out in WR_RESP.
        to_hit    = TO_EN && busy && (tcount_q >= TO_LAST);
        tcount_nx = busy ? (tcount_q + TO_W'(1)) : tcount_q;

        case (state)
            S_IDLE: begin
                // cmd_ready is registered so it stays low during and for one
                // cycle after reset, and drops the cycle after an accept.
                if (cmd_valid && cmd_ready_q) begin
                    addr_nx      = cmd_addr;
                    wdata_nx     = cmd_wdata;
                    wstrb_nx     = cmd_wstrb;
                    tcount_nx    = '0;
                    cmd_ready_nx = 1'b0;
                    if (cmd_write) begin
                        state_nx   = S_WR;
                        awvalid_nx = 1'b1;
                        wvalid_nx  = 1'b1;
                    end else begin
                        state_nx   = S_RD_ADDR;
                        arvalid_nx = 1'b1;
                    end
                end else begin
                    cmd_ready_nx = 1'b1;
                end
            end
            S_WR: begin
                awvalid_nx = aw_left;
                wvalid_nx  = w_left;
                if (!aw_left && !w_left) begin
                    state_nx = S_WR_RESP;
                end else if (to_hit) begin
                    abort = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (m00_axi_bvalid) begin
                    state_nx       = S_RSP;
                    rsp_valid_nx   = 1'b1;
                    rsp_rdata_nx   = '0;
                    rsp_resp_nx    = m00_axi_bresp;
                    rsp_timeout_nx = 1'b0;
                end else if (to_hit) begin
                    abort = 1'b1;
                end
            end
            S_RD_ADDR: begin
                if (m00_axi_arready) begin
                    state_nx   = S_RD_DATA;
                    arvalid_nx = 1'b0;
                end else if (to_hit) begin
                    abort = 1'b1;
                end
            end
            S_RD_DATA: begin
                if (m00_axi_rvalid) begin
                    state_nx       = S_RSP;
                    rsp_valid_nx   = 1'b1;
                    rsp_rdata_nx   = m00_axi_rdata;
                    rsp_resp_nx    = m00_axi_rresp;
                    rsp_timeout_nx = 1'b0;
                end else if (to_hit) begin
                    abort = 1'b1;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_nx     = S_IDLE;
                    rsp_valid_nx = 1'b0;
                    cmd_ready_nx = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Timeout: withdraw every outstanding valid and report SLVERR.
        if (abort) begin
            state_nx       = S_RSP;
            awvalid_nx     = 1'b0;
            wvalid_nx      = 1'b0;
            arvalid_nx     = 1'b0;
            rsp_valid_nx   = 1'b1;
            rsp_rdata_nx   = '0;
            rsp_resp_nx    = 2'b10;
            rsp_timeout_nx = 1'b1;
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_resp        = rsp_resp_q;
    assign rsp_timeout     = rsp_timeout_q;

    assign m00_axi_awaddr  = addr_q;
    assign m00_axi_awprot  = 3'b000;
    assign m00_axi_awvalid = awvalid_q;
    assign m00_axi_wdata   = wdata_q;
    assign m00_axi_wstrb   = wstrb_q;
    assign m00_axi_wvalid  = wvalid_q;
    assign m00_axi_bready  = (state == S_WR_RESP);
    assign m00_axi_araddr  = addr_q;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arvalid = arvalid_q;
    assign m00_axi_rready  = (state == S_RD_DATA);

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_master
// Purpose  : Self-checking bench for axi_lite_master. A configurable AXI-Lite
//            slave model supplies wait states; expected responses are queued
//            at command issue and compared by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axi_lite_master #(
        .C_M00_AXI_DATA_WIDTH (32),
        .C_M00_AXI_ADDR_WIDTH (5),
        .TIMEOUT_CYCLES       (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .cmd_wstrb       (cmd_wstrb),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_resp        (rsp_resp),
        .rsp_timeout     (rsp_timeout),
        .m00_axi_awaddr  (awaddr),
        .m00_axi_awprot  (awprot),
        .m00_axi_awvalid (awvalid),
        .m00_axi_awready (awready),
        .m00_axi_wdata   (wdata),
        .m00_axi_wstrb   (wstrb),
        .m00_axi_wvalid  (wvalid),
        .m00_axi_wready  (wready),
        .m00_axi_bresp   (bresp),
        .m00_axi_bvalid  (bvalid),
        .m00_axi_bready  (bready),
        .m00_axi_araddr  (araddr),
        .m00_axi_arprot  (arprot),
        .m00_axi_arvalid (arvalid),
        .m00_axi_arready (arready),
        .m00_axi_rdata   (rdata),
        .m00_axi_rresp   (rresp),
        .m00_axi_rvalid  (rvalid),
        .m00_axi_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave model ----------------
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    bit          b_never = 1'b0;
    bit          slv_flush = 1'b0;
    logic [31:0] slv_rdata = '0;
    logic [1:0]  slv_rresp = 2'b00;
    logic [1:0]  slv_bresp = 2'b00;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit          aw_got, w_got, b_pend, r_pend;

    assign awready = awvalid && (aw_cnt >= aw_wait);
    assign wready  = wvalid && (w_cnt >= w_wait);
    assign bvalid  = b_pend && !b_never && (b_cnt >= b_wait);
    assign bresp   = slv_bresp;
    assign arready = arvalid && (ar_cnt >= ar_wait);
    assign rvalid  = r_pend && (r_cnt >= r_wait);
    assign rdata   = slv_rdata;
    assign rresp   = slv_rresp;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
        end else if (slv_flush) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            if (bvalid && bready) begin
                b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
            end else begin
                if (awvalid && awready) aw_got <= 1'b1;
                if (wvalid && wready) w_got <= 1'b1;
                if (!b_pend && (aw_got || (awvalid && awready)) &&
                    (w_got || (wvalid && wready)))
                    b_pend <= 1'b1;
                if (b_pend && !bvalid) b_cnt <= b_cnt + 1;
            end
            if (rvalid && rready) begin
                r_pend <= 1'b0; r_cnt <= 0;
            end else begin
                if (arvalid && arready) r_pend <= 1'b1;
                if (r_pend && !rvalid) r_cnt <= r_cnt + 1;
            end
        end
    end

    // ---------------- checking ----------------
    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // monitor: records handshake cycles, checks payload stability, pops scoreboard
    int          aw_hs_cyc, w_hs_cyc, b_hs_cyc, ar_hs_cyc, r_hs_cyc;
    int          rsp_first_cyc, rsp_hs_cyc;
    int          aw_hs_n = 0, b_hs_n = 0, stab_viol = 0;
    logic        bready_at_rsp;
    logic [4:0]  aw_addr_seen, ar_addr_seen;
    logic [31:0] w_data_seen;
    logic [3:0]  w_strb_seen;

    initial begin : monitor
        bit          pv_aw, pv_aw_hs, pv_w, pv_w_hs, pv_ar, pv_ar_hs, pv_rsp;
        logic [4:0]  p_awaddr, p_araddr;
        logic [31:0] p_wdata;
        logic [3:0]  p_wstrb;
        exp_t        e;
        pv_aw = 0; pv_aw_hs = 0; pv_w = 0; pv_w_hs = 0;
        pv_ar = 0; pv_ar_hs = 0; pv_rsp = 0;
        p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wstrb = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pv_aw = 0; pv_w = 0; pv_ar = 0; pv_rsp = 0;
            end else begin
                if (awvalid && awready) begin
                    aw_hs_cyc = cyc; aw_hs_n++; aw_addr_seen = awaddr;
                end
                if (wvalid && wready) begin
                    w_hs_cyc = cyc; w_data_seen = wdata; w_strb_seen = wstrb;
                end
                if (bvalid && bready) begin b_hs_cyc = cyc; b_hs_n++; end
                if (arvalid && arready) begin ar_hs_cyc = cyc; ar_addr_seen = araddr; end
                if (rvalid && rready) r_hs_cyc = cyc;
                if (pv_aw && !pv_aw_hs && (!awvalid || awaddr !== p_awaddr)) stab_viol++;
                if (pv_w && !pv_w_hs && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb))
                    stab_viol++;
                if (pv_ar && !pv_ar_hs && (!arvalid || araddr !== p_araddr)) stab_viol++;
                if (rsp_valid && !pv_rsp) begin
                    rsp_first_cyc = cyc; bready_at_rsp = bready;
                end
                if (rsp_valid && rsp_ready) begin
                    rsp_hs_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_rsp: got rdata 0x%0h resp %0d, expected none",
                                 rsp_rdata, rsp_resp);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_resp", {30'd0, rsp_resp}, {30'd0, e.resp});
                        check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
                    end
                end
                pv_aw = awvalid; pv_aw_hs = awvalid && awready; p_awaddr = awaddr;
                pv_w  = wvalid;  pv_w_hs  = wvalid && wready;   p_wdata = wdata; p_wstrb = wstrb;
                pv_ar = arvalid; pv_ar_hs = arvalid && arready; p_araddr = araddr;
                pv_rsp = rsp_valid;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_cmd(input bit wr, input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [31:0] er,
                             input logic [1:0] eresp, input logic eto);
        exp_t e;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        e.rdata = er; e.resp = eresp; e.to = eto;
        exp_q.push_back(e);
    endtask

    // Returns the cycle in which the command was accepted (T0).
    task automatic wait_accept(output int acc);
        bit got;
        got = 0; acc = -1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) begin acc = cyc; got = 1; end
        end
        if (!got) fail_now("cmd_accept");
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send(input bit wr, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] er,
                        input logic [1:0] eresp, input logic eto, output int acc);
        drive_cmd(wr, a, d, s, er, eresp, eto);
        wait_accept(acc);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) fail_now("rsp_wait");
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin : stim
        int c0;
        rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_valids", {28'd0, awvalid, wvalid, arvalid, rsp_valid}, 32'd0);
        check("rst_readies", {30'd0, bready, rready}, 32'd0);
        check("rst_rsp_payload", rsp_rdata | {29'd0, rsp_resp, rsp_timeout}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // 1: zero-wait write
        send(1'b1, 5'h04, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, 1'b0, c0);
        wait_idle();
        check("wr_aw_cycle", aw_hs_cyc, c0 + 1);
        check("wr_w_cycle", w_hs_cyc, c0 + 1);
        check("wr_b_cycle", b_hs_cyc, c0 + 2);
        check("wr_rsp_cycle", rsp_first_cyc, c0 + 3);
        check("wr_awaddr", {27'd0, aw_addr_seen}, 32'h04);
        check("wr_wdata", w_data_seen, 32'hDEADBEEF);
        check("wr_wstrb", {28'd0, w_strb_seen}, 32'hF);

        // 2: read, rvalid after 3 wait cycles
        r_wait = 3; slv_rdata = 32'h12345678;
        send(1'b0, 5'h08, 32'h0, 4'h0, 32'h12345678, 2'b00, 1'b0, c0);
        wait_idle();
        check("rd_araddr", {27'd0, ar_addr_seen}, 32'h08);
        check("rd_r_cycle", r_hs_cyc, c0 + 5);
        check("rd_rsp_cycle", rsp_first_cyc, c0 + 6);
        r_wait = 0;

        // 3: W delayed 4 cycles after AW; DECERR passed through
        begin
            int n0;
            n0 = aw_hs_n;
            w_wait = 4; slv_bresp = 2'b11;
            send(1'b1, 5'h14, 32'hCAFE0123, 4'b0101, 32'h0, 2'b11, 1'b0, c0);
            @(negedge clk);
            @(negedge clk);
            check("split_aw_dropped", {30'd0, awvalid, wvalid}, 32'b01);
            wait_idle();
            check("split_aw_count", aw_hs_n - n0, 1);
            check("split_w_cycle", w_hs_cyc, c0 + 5);
            check("split_wdata", w_data_seen, 32'hCAFE0123);
            check("split_rsp_cycle", rsp_first_cyc, c0 + 7);
            w_wait = 0; slv_bresp = 2'b00;
        end

        // 4: slave never answers B -> timeout after 16 busy cycles
        begin
            int nb;
            nb = b_hs_n;
            b_never = 1'b1;
            send(1'b1, 5'h00, 32'h00000001, 4'hF, 32'h0, 2'b10, 1'b1, c0);
            wait_idle();
            check("to_rsp_cycle", rsp_first_cyc, c0 + 17);
            check("to_bready_low", {31'd0, bready_at_rsp}, 32'd0);
            check("to_no_b_hs", b_hs_n - nb, 0);
            b_never = 1'b0;
            slv_flush = 1'b1;
            @(posedge clk); #1;
            slv_flush = 1'b0;
        end

        // 5: response back-pressure, SLVERR passed through
        begin
            bit seen;
            rsp_ready = 1'b0; slv_rdata = 32'hA5A50F0F; slv_rresp = 2'b10;
            send(1'b0, 5'h0C, 32'h0, 4'h0, 32'hA5A50F0F, 2'b10, 1'b0, c0);
            seen = 0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (rsp_valid) seen = 1;
            end
            if (!seen) fail_now("hold_rsp_valid");
            for (int k = 0; k < 5; k++) begin
                check("hold_rdata", rsp_rdata, 32'hA5A50F0F);
                check("hold_valid_ready", {30'd0, rsp_valid, cmd_ready}, 32'b10);
                @(negedge clk);
            end
            @(posedge clk); #1;
            rsp_ready = 1'b1; slv_rresp = 2'b00;
            drive_cmd(1'b1, 5'h18, 32'h00FF00FF, 4'hC, 32'h0, 2'b00, 1'b0);
            wait_accept(c0);
            check("next_accept_cycle", c0, rsp_hs_cyc + 1);
            wait_idle();
        end

        // 6: reset while awvalid is high, then a clean read
        aw_wait = 20;
        drive_cmd(1'b1, 5'h1C, 32'h11112222, 4'hF, 32'h0, 2'b00, 1'b0);
        wait_accept(c0);
        @(negedge clk);
        check("mid_awvalid_high", {31'd0, awvalid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_valids_low", {30'd0, awvalid, wvalid}, 32'd0);
        void'(exp_q.pop_back());
        aw_wait = 0;
        repeat (2) @(negedge clk);
        check("rst_no_rsp", {30'd0, rsp_valid, cmd_ready}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        slv_rdata = 32'h0BADF00D;
        send(1'b0, 5'h10, 32'h0, 4'h0, 32'h0BADF00D, 2'b00, 1'b0, c0);
        wait_idle();
        check("post_rst_ar_cycle", ar_hs_cyc, c0 + 1);
        check("post_rst_r_cycle", r_hs_cyc, c0 + 2);
        check("post_rst_rsp_cycle", rsp_first_cyc, c0 + 3);

        check("scoreboard_empty", exp_q.size(), 0);
        check("payload_stability", stab_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
